// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared types and constants for the forwarding / hazard unit.
//   fwd_tag_t      : in-flight destination tag {valid, dst, rw, mtr}
//   FWD_*          : EX operand mux select encodings
//   BR_*           : branch operand mux select encodings
//   stall_state_t  : load-use stall FSM states
// The tag address field is sized to TAG_ADDR_W so one struct type serves
// every ADDR_W up to that width; narrower addresses are zero-extended.
// Optional build macro used by importers: ZERO_REG_EN.
// ---------------------------------------------------------------------------
package fwd_pkg;

    localparam int TAG_ADDR_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [TAG_ADDR_W-1:0] dst;
        logic                  rw;
        logic                  mtr;
    } fwd_tag_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam logic [1:0] BR_RF  = 2'd0;
    localparam logic [1:0] BR_EX  = 2'd1;
    localparam logic [1:0] BR_MEM = 2'd2;
    localparam logic [1:0] BR_WB  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stall_state_t;

    // A bubble carries no valid producer and therefore never matches.
    function automatic fwd_tag_t make_bubble();
        return '0;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Compares one register address against one pipeline tag.
// Ports:
//   tag_valid, tag_rw, tag_dst : fields of the tag being inspected
//   addr                        : source address read by the consumer
//   hit                         : tag is a live register writer of addr
// Build macro ZERO_REG_EN: when defined, address 0 is the hardwired zero
// register and never produces a hit.
// ---------------------------------------------------------------------------
module fwd_match
    import fwd_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic                  tag_valid,
    input  logic                  tag_rw,
    input  logic [TAG_ADDR_W-1:0] tag_dst,
    input  logic [ADDR_W-1:0]     addr,
    output logic                  hit
);

    logic [TAG_ADDR_W-1:0] addr_ext;

    always_comb begin
        addr_ext = TAG_ADDR_W'(addr);
        hit      = tag_valid && tag_rw && (tag_dst == addr_ext);
`ifdef ZERO_REG_EN
        // r0 always reads as zero, so nothing ever needs forwarding to it.
        if (addr_ext == '0) begin
            hit = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Tracks destination tags of instructions in EX/MEM/WB and produces:
//   - registered per-operand EX forward selects (0 RF, 1 WB, 2 MEM ALU)
//   - combinational branch-operand select (0 RF, 1 EX, 2 MEM, 3 WB)
//   - load-use stall, lasting LOAD_LAT cycles per hazard
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : kill wrong-path instructions in EX and MEM
//   id_valid          : ID holds a real instruction
//   id_src            : NUM_SRC packed source addresses
//   id_src_used       : per-operand register-read flags
//   id_dst, id_rw     : destination address, register write
//   id_mtr            : result comes from memory (load)
//   id_is_in          : IN instruction, register operands ignored
//   id_br_src         : branch register read in ID
//   id_br_used        : ID instruction is a register branch
//   ex_fwd_sel        : 2 bits per operand, registered
//   br_fwd_sel        : branch operand select
//   stall             : hold PC and F/D, bubble into ID/EX
// Build macro ZERO_REG_EN: r0 is hardwired zero (see fwd_match).
// ---------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [ADDR_W-1:0]         id_dst,
    input  logic                      id_rw,
    input  logic                      id_mtr,
    input  logic                      id_is_in,
    input  logic [ADDR_W-1:0]         id_br_src,
    input  logic                      id_br_used,
    output logic [2*NUM_SRC-1:0]      ex_fwd_sel,
    output logic [1:0]                br_fwd_sel,
    output logic                      stall
);

    fwd_tag_t t_ex;
    fwd_tag_t t_mem;
    fwd_tag_t t_wb;
    fwd_tag_t id_tag;

    logic [NUM_SRC-1:0]   src_hit_ex;
    logic [NUM_SRC-1:0]   src_hit_mem;
    logic                 br_hit_ex;
    logic                 br_hit_mem;
    logic                 br_hit_wb;
    logic                 hazard;
    logic [2*NUM_SRC-1:0] ex_sel_next;
    stall_state_t         state_q;
    logic [1:0]           cnt_q;
    logic                 unused_wb_mtr;

    assign id_tag        = '{valid: 1'b1, dst: TAG_ADDR_W'(id_dst), rw: id_rw, mtr: id_mtr};
    assign unused_wb_mtr = t_wb.mtr;

    // One comparator per source operand against the EX and MEM producers.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_match #(.ADDR_W(ADDR_W)) u_ex (
            .tag_valid (t_ex.valid),
            .tag_rw    (t_ex.rw),
            .tag_dst   (t_ex.dst),
            .addr      (id_src[k*ADDR_W +: ADDR_W]),
            .hit       (src_hit_ex[k])
        );
        fwd_match #(.ADDR_W(ADDR_W)) u_mem (
            .tag_valid (t_mem.valid),
            .tag_rw    (t_mem.rw),
            .tag_dst   (t_mem.dst),
            .addr      (id_src[k*ADDR_W +: ADDR_W]),
            .hit       (src_hit_mem[k])
        );
    end

    // The branch resolves in ID, so it can pick from every later stage.
    fwd_match #(.ADDR_W(ADDR_W)) u_br_ex (
        .tag_valid (t_ex.valid),
        .tag_rw    (t_ex.rw),
        .tag_dst   (t_ex.dst),
        .addr      (id_br_src),
        .hit       (br_hit_ex)
    );
    fwd_match #(.ADDR_W(ADDR_W)) u_br_mem (
        .tag_valid (t_mem.valid),
        .tag_rw    (t_mem.rw),
        .tag_dst   (t_mem.dst),
        .addr      (id_br_src),
        .hit       (br_hit_mem)
    );
    fwd_match #(.ADDR_W(ADDR_W)) u_br_wb (
        .tag_valid (t_wb.valid),
        .tag_rw    (t_wb.rw),
        .tag_dst   (t_wb.dst),
        .addr      (id_br_src),
        .hit       (br_hit_wb)
    );

    // A load in EX cannot supply its data to the instruction right behind it.
    // Flush kills that load, so it also cancels any stall in the same cycle.
    always_comb begin
        hazard = id_valid && t_ex.mtr &&
                 ((|(src_hit_ex & id_src_used)) || (br_hit_ex && id_br_used));
        stall  = !flush && ((state_q == ST_HOLD) || hazard);
    end

    // IDLE covers the first stall cycle on its own; HOLD adds the remaining
    // LOAD_LAT-1 cycles, counting down and leaving when the count reaches 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= 2'(LOAD_LAT - 1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 2'd1) begin
                        state_q <= ST_IDLE;
                    end
                    cnt_q <= cnt_q - 2'd1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 2'd0;
                end
            endcase
        end
    end

    // Tags advance every cycle. The ID instruction only enters EX when it is
    // real and not held; flush invalidates what moves into EX and MEM while
    // the instruction leaving MEM still completes into WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_ex  <= make_bubble();
            t_mem <= make_bubble();
            t_wb  <= make_bubble();
        end else begin
            t_wb  <= t_mem;
            t_mem <= t_ex;
            if (flush) begin
                t_mem.valid <= 1'b0;
            end
            if (id_valid && !stall && !flush) begin
                t_ex <= id_tag;
            end else begin
                t_ex <= make_bubble();
            end
        end
    end

    // The tag now in EX will be in MEM when this consumer is in EX, hence the
    // MEM select; a load there has no ALU result, which is the stall case.
    always_comb begin
        ex_sel_next = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used[k] && !id_is_in && !stall) begin
                if (src_hit_ex[k] && !t_ex.mtr) begin
                    ex_sel_next[2*k +: 2] = FWD_MEM;
                end else if (src_hit_mem[k]) begin
                    ex_sel_next[2*k +: 2] = FWD_WB;
                end
            end
        end
    end

    // Selects are registered alongside the ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_fwd_sel <= '0;
        end else if (flush) begin
            ex_fwd_sel <= '0;
        end else begin
            ex_fwd_sel <= ex_sel_next;
        end
    end

    // Youngest non-load producer wins; WB data is valid for loads too.
    always_comb begin
        br_fwd_sel = BR_RF;
        if (id_br_used) begin
            if (br_hit_ex && !t_ex.mtr) begin
                br_fwd_sel = BR_EX;
            end else if (br_hit_mem && !t_mem.mtr) begin
                br_fwd_sel = BR_MEM;
            end else if (br_hit_wb) begin
                br_fwd_sel = BR_WB;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Drives three fwd_hazard_unit instances (LOAD_LAT = 1, 2, 3) from shared
// inputs and compares them against a per-instance model of the pipeline
// tags and remaining stall cycles. Build macro ZERO_REG_EN is honoured.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       idValid;
    logic [5:0] idSrc;
    logic [1:0] idSrcUsed;
    logic [2:0] idDst;
    logic       idRw;
    logic       idMtr;
    logic       idIsIn;
    logic [2:0] idBrSrc;
    logic       idBrUsed;

    logic [3:0] exSel [3];
    logic [1:0] brSel [3];
    logic       stallO [3];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit #(.ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(idValid),
        .id_src(idSrc), .id_src_used(idSrcUsed), .id_dst(idDst), .id_rw(idRw),
        .id_mtr(idMtr), .id_is_in(idIsIn), .id_br_src(idBrSrc),
        .id_br_used(idBrUsed), .ex_fwd_sel(exSel[0]), .br_fwd_sel(brSel[0]),
        .stall(stallO[0])
    );
    fwd_hazard_unit #(.ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(idValid),
        .id_src(idSrc), .id_src_used(idSrcUsed), .id_dst(idDst), .id_rw(idRw),
        .id_mtr(idMtr), .id_is_in(idIsIn), .id_br_src(idBrSrc),
        .id_br_used(idBrUsed), .ex_fwd_sel(exSel[1]), .br_fwd_sel(brSel[1]),
        .stall(stallO[1])
    );
    fwd_hazard_unit #(.ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(idValid),
        .id_src(idSrc), .id_src_used(idSrcUsed), .id_dst(idDst), .id_rw(idRw),
        .id_mtr(idMtr), .id_is_in(idIsIn), .id_br_src(idBrSrc),
        .id_br_used(idBrUsed), .ex_fwd_sel(exSel[2]), .br_fwd_sel(brSel[2]),
        .stall(stallO[2])
    );

    // Reference model: the instruction occupying each later stage, plus the
    // number of stall cycles still owed after the current one.
    typedef struct {
        bit       v;
        bit [2:0] dst;
        bit       rw;
        bit       mtr;
    } tagT;

    tagT      mEx [3];
    tagT      mMem [3];
    tagT      mWb [3];
    int       remain [3];
    bit [3:0] mSel [3];
    int       lat [3] = '{1, 2, 3};
    int       stallSeen [3];

    function automatic bit writes(tagT t, bit [2:0] a);
        bit h;
        h = t.v && t.rw && (t.dst == a);
`ifdef ZERO_REG_EN
        if (a == 3'd0) h = 1'b0;
`endif
        return h;
    endfunction

    function automatic bit expHazard(int i);
        bit anyUse;
        anyUse = (idSrcUsed[0] && writes(mEx[i], idSrc[2:0])) ||
                 (idSrcUsed[1] && writes(mEx[i], idSrc[5:3])) ||
                 (idBrUsed && writes(mEx[i], idBrSrc));
        return idValid && mEx[i].mtr && anyUse;
    endfunction

    function automatic bit expStall(int i);
        return !flush && (remain[i] > 0 || expHazard(i));
    endfunction

    function automatic bit [1:0] expBr(int i);
        if (!idBrUsed) return 2'd0;
        if (writes(mEx[i], idBrSrc) && !mEx[i].mtr) return 2'd1;
        if (writes(mMem[i], idBrSrc) && !mMem[i].mtr) return 2'd2;
        if (writes(mWb[i], idBrSrc)) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit [1:0] opSel(int i, int k, bit s);
        bit [2:0] a;
        a = (k == 0) ? idSrc[2:0] : idSrc[5:3];
        if (!idSrcUsed[k] || idIsIn || s) return 2'd0;
        if (writes(mEx[i], a) && !mEx[i].mtr) return 2'd2;
        if (writes(mMem[i], a)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mEx[i]    = '{v: 0, dst: 0, rw: 0, mtr: 0};
            mMem[i]   = mEx[i];
            mWb[i]    = mEx[i];
            remain[i] = 0;
            mSel[i]   = 4'd0;
        end
    endtask

    task automatic modelStep();
        bit s;
        bit hz;
        tagT bubble;
        bubble = '{v: 0, dst: 0, rw: 0, mtr: 0};
        for (int i = 0; i < 3; i++) begin
            s  = expStall(i);
            hz = expHazard(i);
            if (flush) begin
                mSel[i]   = 4'd0;
                mWb[i]    = mMem[i];
                mMem[i]   = mEx[i];
                mMem[i].v = 1'b0;
                mEx[i]    = bubble;
                remain[i] = 0;
            end else begin
                mSel[i] = {opSel(i, 1, s), opSel(i, 0, s)};
                mWb[i]  = mMem[i];
                mMem[i] = mEx[i];
                if (idValid && !s) mEx[i] = '{v: 1, dst: idDst, rw: idRw, mtr: idMtr};
                else               mEx[i] = bubble;
                if (remain[i] > 0) remain[i] = remain[i] - 1;
                else if (hz)       remain[i] = lat[i] - 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit [2:0] s0, input bit [2:0] s1,
                                 input bit [1:0] used, input bit [2:0] dst,
                                 input bit rw, input bit mtr, input bit isIn,
                                 input bit [2:0] brSrc, input bit brUsed, input bit fl);
        idValid   = v;
        idSrc     = {s1, s0};
        idSrcUsed = used;
        idDst     = dst;
        idRw      = rw;
        idMtr     = mtr;
        idIsIn    = isIn;
        idBrSrc   = brSrc;
        idBrUsed  = brUsed;
        flush     = fl;
    endtask

    // One cycle: combinational outputs checked before the edge, registered
    // selects checked just after it. Returns on the following falling edge.
    task automatic tick();
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall_lat%0d", i + 1), 8'(stallO[i]), 8'(expStall(i)));
            checkOutput($sformatf("br_sel_lat%0d", i + 1), 8'(brSel[i]), 8'(expBr(i)));
            stallSeen[i] = int'(stallO[i]);
        end
        modelStep();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("ex_sel_lat%0d", i + 1), 8'(exSel[i]), 8'(mSel[i]));
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic pulseReset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_stall_lat%0d", i + 1), 8'(stallO[i]), 8'd0);
            checkOutput($sformatf("rst_br_lat%0d", i + 1), 8'(brSel[i]), 8'd0);
            checkOutput($sformatf("rst_ex_lat%0d", i + 1), 8'(exSel[i]), 8'd0);
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt [3];
        int expZ;
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        #2;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_ex_lat%0d", i + 1), 8'(exSel[i]), 8'd0);
            checkOutput($sformatf("reset_stall_lat%0d", i + 1), 8'(stallO[i]), 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // ALU producer directly ahead forwards from MEM.
        applyStimulus(1, 0, 0, 2'b00, 3'd1, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 3'd1, 0, 2'b01, 3'd5, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case1_sel_lat%0d", i + 1), 8'(exSel[i][1:0]), 8'd2);

        // Producer two ahead forwards from WB; youngest of two writers wins.
        applyStimulus(1, 0, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0, 0, 2'b00, 3'd7, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0, 3'd2, 2'b10, 3'd6, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case2_wb_lat%0d", i + 1), 8'(exSel[i][3:2]), 8'd1);
        applyStimulus(1, 0, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0, 0, 2'b00, 3'd2, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 3'd2, 3'd2, 2'b11, 3'd6, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case2_young_lat%0d", i + 1), 8'(exSel[i]), 8'hA);

        // Load-use: stall length equals LOAD_LAT.
        applyStimulus(1, 0, 0, 2'b00, 3'd3, 1, 1, 0, 0, 0, 0); tick();
        applyStimulus(1, 3'd3, 0, 2'b01, 3'd6, 0, 0, 0, 0, 0, 0);
        cnt = '{0, 0, 0};
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int i = 0; i < 3; i++) cnt[i] += stallSeen[i];
        end
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case3_stalls_lat%0d", i + 1), 8'(cnt[i]), 8'(i + 1));

        // Branch on a loaded register, then on an ALU result.
        drain(3);
        applyStimulus(1, 0, 0, 2'b00, 3'd4, 1, 1, 0, 0, 0, 0); tick();
        applyStimulus(1, 0, 0, 2'b00, 3'd7, 0, 0, 0, 3'd4, 1, 0);
        for (int c = 0; c < 5; c++) tick();
        drain(3);
        applyStimulus(1, 0, 0, 2'b00, 3'd4, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0, 0, 2'b00, 3'd7, 0, 0, 0, 3'd4, 1, 0);
        #1;
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case4_br_ex_lat%0d", i + 1), 8'(brSel[i]), 8'd1);
        tick();

        // Flush in the same cycle as a load-use hazard.
        drain(3);
        applyStimulus(1, 0, 0, 2'b00, 3'd5, 1, 1, 0, 0, 0, 0); tick();
        applyStimulus(1, 3'd5, 0, 2'b01, 3'd6, 0, 0, 0, 0, 0, 1);
        #1;
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case5_flush_stall_lat%0d", i + 1), 8'(stallO[i]), 8'd0);
        tick();
        applyStimulus(1, 0, 3'd5, 2'b10, 3'd6, 0, 0, 0, 0, 0, 0);
        #1;
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case5_after_stall_lat%0d", i + 1), 8'(stallO[i]), 8'd0);
        tick();
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case5_sel_lat%0d", i + 1), 8'(exSel[i][3:2]), 8'd0);

        // Reset in the middle of a three-cycle stall, then r0 traffic.
        drain(3);
        applyStimulus(1, 0, 0, 2'b00, 3'd6, 1, 1, 0, 0, 0, 0); tick();
        applyStimulus(1, 3'd6, 0, 2'b01, 3'd7, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        #1;
        checkOutput("case6_hold_stall", 8'(stallO[2]), 8'd1);
        pulseReset();
        #1;
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case6_post_rst_stall_lat%0d", i + 1), 8'(stallO[i]), 8'd0);
        tick();
        drain(1);
        applyStimulus(1, 0, 0, 2'b00, 3'd0, 1, 1, 0, 0, 0, 0); tick();
        applyStimulus(1, 3'd0, 0, 2'b01, 3'd7, 0, 0, 0, 3'd0, 1, 0);
`ifdef ZERO_REG_EN
        expZ = 0;
`else
        expZ = 1;
`endif
        #1;
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("case6_r0_stall_lat%0d", i + 1), 8'(stallO[i]), 8'(expZ));
        tick();
        drain(3);

        // Randomized traffic with a small address space for frequent hits.
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 7) != 0,
                          3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 9) == 0, 3'($urandom_range(0, 3)),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            if (c == 200) pulseReset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational forwarding logic. Tracks in-flight destination tags through EX/MEM/WB internally instead of taking them as ports.
- Produces registered per-operand ALU forward selects, branch-operand forward select, and load-use stall control with a multi-cycle stall FSM.
- Sits beside the ID/EX pipeline register; consumes ID-stage decode fields and drives EX muxes, the branch mux and the F/D stall enable.

Parameters:
- ADDR_W, 3, register address width.
- NUM_SRC, 2, ALU source operands per instruction.
- LOAD_LAT, 1, bubbles inserted on load-use hazard (1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill wrong-path instructions in EX and MEM.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*ADDR_W  source addresses; operand k at [k*ADDR_W +: ADDR_W].
- id_src_used  in  NUM_SRC  operand k reads the register file.
- id_dst  in  ADDR_W  destination address.
- id_rw  in  1  writes a register.
- id_mtr  in  1  result comes from memory (load).
- id_is_in  in  1  IN instruction; register operands ignored.
- id_br_src  in  ADDR_W  branch target register read in ID.
- id_br_used  in  1  ID instruction is a register branch.
- ex_fwd_sel  out  2*NUM_SRC  per-operand EX select: 0 regfile/ID-EX, 1 WB data, 2 MEM ALU result.
- br_fwd_sel  out  2  0 regfile, 1 EX ALU out, 2 MEM ALU out, 3 WB data.
- stall  out  1  hold PC and F/D, insert bubble into ID/EX.

Behaviour:
- Tag = {valid, dst, rw, mtr}. Three registers: T_EX, T_MEM, T_WB.
- Each cycle: T_WB<=T_MEM; T_MEM<=T_EX; T_EX<=ID tag if id_valid && !stall, else bubble (valid=0).
- A tag matches address a when valid && rw && dst==a.
- ex_fwd_sel, operand k, registered at the edge the instruction enters EX:
  - 2 if T_EX matches and !T_EX.mtr.
  - else 1 if T_MEM matches.
  - else 0. WB-stage writes are covered by the write-through register file.
  - Forced 0 if id_src_used[k]==0, id_is_in==1, or stall==1.
  - Youngest producer wins.
- Load-use hazard (combinational): id_valid && T_EX.mtr && T_EX matches any used id_src or the used id_br_src.
- Stall FSM, states IDLE and HOLD; cnt is 2 bits.
  - IDLE: hazard -> stall=1 in the same cycle. If LOAD_LAT>1, go to HOLD with cnt=LOAD_LAT-1.
  - HOLD: stall=1; cnt decrements; leave to IDLE when cnt==1.
  - Total stall cycles per hazard = LOAD_LAT.
- Branch select (combinational, from current tags):
  - 1 if T_EX matches and !mtr.
  - else 2 if T_MEM matches and !mtr.
  - else 3 if T_WB matches.
  - else 0.
  - Forced 0 if !id_br_used.
- flush: synchronously clears T_EX.valid and T_MEM.valid (T_WB retained). FSM returns to IDLE. ex_fwd_sel cleared to 0. Flush beats a simultaneous hazard; no stall in the cycle after flush.
- Reset (async, rst_n=0): all tags invalid, ex_fwd_sel=0, FSM IDLE, cnt=0, stall=0, br_fwd_sel=0.
- Bubble tags never match. A consumer reading two operands from the same producer gets identical selects.

Optional Feature:
- ZERO_REG_EN: address 0 is a hardwired zero register. Tags with dst==0 never match, so no forward and no stall on r0.
- Without the macro, r0 is an ordinary register.

Decomposition:
- Package fwd_pkg:
  - Tag struct typedef.
  - Select encodings FWD_RF/FWD_WB/FWD_MEM and BR_RF/BR_EX/BR_MEM/BR_WB.
  - FSM state enum.
- One sub-module, fwd_match: a single address-vs-tag comparator (with the ZERO_REG_EN guard), instantiated per operand per stage.

Test Plan:
- Case 1:
  - Stimulus: ADD r1 (rw=1, mtr=0) issued, next cycle SUB reads r1 as operand 0.
  - Response: stall=0; ex_fwd_sel[1:0]=2 during SUB's EX cycle.
- Case 2:
  - Stimulus: ADD r2, then unrelated NOP, then AND reads r2 on operand 1.
  - Response: ex_fwd_sel[3:2]=1; r2 written twice back-to-back, and the youngest selects 2.
- Case 3:
  - Stimulus: LDD r3, then OR reads r3, LOAD_LAT=1.
  - Response: stall=1 for exactly 1 cycle; bubble in EX; OR then gets sel 1.
  - Same with LOAD_LAT=2: 2 stall cycles, then sel 0.
- Case 4:
  - Stimulus: LDD r4, then a branch on r4 (id_br_used=1).
  - Response: stall=1, then br_fwd_sel=3 once the load is in WB.
  - Non-load producer of r4 in EX -> br_fwd_sel=1.
- Case 5:
  - Stimulus: flush asserted in the same cycle as a load-use hazard.
  - Response: stall=0 next cycle; T_EX/T_MEM invalid; later consumers of the flushed dst get sel 0.
- Case 6:
  - Stimulus: rst_n pulsed low mid-HOLD with LOAD_LAT=3; with ZERO_REG_EN, producer writes r0 and consumer reads r0.
  - Response: after reset, stall=0 immediately and all selects are 0; the r0 consumer sees no forward and no stall.
